// File: rtl/lut_neuron_pkg.sv
// Shared definitions for the reprogrammable LogicNets neuron table loader.
// Holds the neuron geometry, the load FSM state type, and the helper that
// maps stream order onto table addresses.
package lut_neuron_pkg;

    localparam int FANIN    = 4;   // neuron inputs per LUT
    localparam int IN_W     = 2;   // bits per neuron input
    localparam int OUT_BITS = 2;   // output bits per table entry

    function automatic int addr_w(input int fanin, input int in_w);
        return fanin * in_w;
    endfunction

    localparam int ADDR_W = addr_w(FANIN, IN_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        ERROR  = 2'd3
    } load_state_e;

    // The table generator enumerates entries with input 0 in the least
    // significant counter digit, while lookups present input 0 in the most
    // significant address field. Reversing the field order bridges the two.
    function automatic logic [ADDR_W-1:0] addr_reorder(input logic [ADDR_W-1:0] cnt);
        logic [ADDR_W-1:0] a;
        a = '0;
        for (int i = 0; i < FANIN; i++)
            a[i*IN_W +: IN_W] = cnt[(FANIN-1-i)*IN_W +: IN_W];
        return a;
    endfunction

endpackage

// File: rtl/lut_bank_ram.sv
// Two-bank truth-table storage: one write port into either bank, one
// registered read from either bank. The read register can be forced to zero
// so the neuron outputs zero while no committed table exists.
// Ports:
//   clk, rst_n        clock / async active-low reset (read register only)
//   we, wr_bank, wr_addr, wr_data   write port
//   rd_bank, rd_addr  read address (sampled every cycle)
//   rd_zero           return zero instead of the stored entry
//   rd_data           registered read data
module lut_bank_ram #(
    parameter int ADDR_W   = 8,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic                wr_bank,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [OUT_BITS-1:0] wr_data,
    input  logic                rd_bank,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_zero,
    output logic [OUT_BITS-1:0] rd_data
);

    (* ram_style = "distributed" *)
    logic [OUT_BITS-1:0] mem [2**(ADDR_W+1)];

    // Contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[{wr_bank, wr_addr}] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else
            rd_data <= rd_zero ? '0 : mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/lut_neuron_table_loader.sv
// Runtime writer for one neuron truth table. A load streams 2**ADDR_W
// entries into the shadow bank; a well-formed load then swaps banks in a
// single COMMIT cycle, so lookups never observe a partial table.
// Ports:
//   clk, rst_n                         clock / async active-low reset
//   cfg_start                          start or restart a load
//   s_valid, s_ready, s_data, s_last   entry stream
//   busy, done, err, tbl_valid         load status
//   in_valid, in_data                  lookup request
//   out_valid, out_data                lookup result (1-cycle latency)
module lut_neuron_table_loader
    import lut_neuron_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [OUT_BITS-1:0] s_data,
    input  logic                s_last,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                tbl_valid,
    input  logic                in_valid,
    input  logic [ADDR_W-1:0]   in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);

    load_state_e       state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              bank_sel;
    logic              accept;
    logic              cnt_last;
    logic              restart;

    assign accept   = s_valid & s_ready;
    assign cnt_last = (cnt == {ADDR_W{1'b1}});
    assign restart  = cfg_start & (state != COMMIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (cfg_start) state_nxt = LOAD;
            LOAD: begin
                if (cfg_start)
                    state_nxt = LOAD;
                else if (accept) begin
                    if (cnt_last && s_last)      state_nxt = COMMIT;
                    else if (cnt_last || s_last) state_nxt = ERROR;
                end
            end
            COMMIT: state_nxt = IDLE;
            ERROR:  state_nxt = cfg_start ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        s_ready = (state == LOAD);
        busy    = (state == LOAD) || (state == COMMIT);
        done    = (state == COMMIT);
    end

    // Counter, bank select and sticky status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bank_sel  <= 1'b0;
            tbl_valid <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (restart)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + ADDR_W'(1);

            if (restart)
                err <= 1'b0;
            else if (state == ERROR)
                err <= 1'b1;

            if (state == COMMIT) begin
                bank_sel  <= ~bank_sel;
                tbl_valid <= 1'b1;
            end
        end
    end

    // A beat coinciding with a restart belongs to the abandoned load.
    lut_bank_ram #(
        .ADDR_W   (ADDR_W),
        .OUT_BITS (OUT_BITS)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept & ~cfg_start),
        .wr_bank (~bank_sel),
        .wr_addr (addr_reorder(cnt)),
        .wr_data (s_data),
        .rd_bank (bank_sel),
        .rd_addr (in_data),
        .rd_zero (~tbl_valid),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_lut_neuron_table_loader.sv
module tb_lut_neuron_table_loader;
    import lut_neuron_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_start = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [OUT_BITS-1:0] s_data = '0;
    logic                s_last = 1'b0;
    logic                busy, done, err, tbl_valid;
    logic                in_valid = 1'b0;
    logic [ADDR_W-1:0]   in_data = '0;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;

    lut_neuron_table_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tbl_valid (tbl_valid),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the table the neuron should currently answer from.
    logic [1:0] active_m [256];
    bit         tbl_m = 1'b0;
    logic [1:0] ld_data  [256];

    bit         lk_en = 1'b0;
    bit         lk_force = 1'b0;
    logic [7:0] lk_addr = 8'h00;
    bit         have_prev = 1'b0;
    bit         prev_valid = 1'b0;
    logic [1:0] exp_prev = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entry k of the stream holds the output for inputs x_i = base-4 digit i
    // of k; input 0 is the most significant address field.
    function automatic int entry_addr(input int k);
        int a = 0;
        for (int i = 0; i < 4; i++)
            a += ((k / (4 ** i)) % 4) * (4 ** (3 - i));
        return a;
    endfunction

    task automatic model_commit();
        for (int k = 0; k < 256; k++)
            active_m[entry_addr(k)] = ld_data[k];
        tbl_m = 1'b1;
    endtask

    // Lookup driver/checker, on the falling edge so it never races the
    // main sequence, which updates the model just after rising edges.
    always @(negedge clk) begin
        if (lk_en) begin
            if (have_prev) begin
                chk("lk_valid", {31'b0, out_valid}, {31'b0, prev_valid});
                if (prev_valid)
                    chk("lk_data", {30'b0, out_data}, {30'b0, exp_prev});
            end
            prev_valid = lk_force ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid   = prev_valid;
            in_data    = lk_force ? lk_addr : 8'($urandom_range(0, 255));
            exp_prev   = tbl_m ? active_m[in_data] : 2'b00;
            have_prev  = 1'b1;
        end else begin
            in_valid  = 1'b0;
            have_prev = 1'b0;
        end
    end

    task automatic start_load();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk("start_ready", {31'b0, s_ready}, 32'd1);
        chk("start_err", {31'b0, err}, 32'd0);
    endtask

    task automatic send_beats(input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0;
            while ($urandom_range(0, 3) == 0) step();
            s_valid = 1'b1;
            s_data  = ld_data[i];
            s_last  = (i == last_idx);
            step();
            if (i < n - 1) chk("beat_done", {31'b0, done}, 32'd0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_commit();
        chk("commit_done", {31'b0, done}, 32'd1);
        chk("commit_busy", {31'b0, busy}, 32'd1);
        step();
        model_commit();
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("tbl_valid", {31'b0, tbl_valid}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic expect_error();
        chk("err_done", {31'b0, done}, 32'd0);
        chk("err_busy", {31'b0, busy}, 32'd0);
        step();
        chk("err_set", {31'b0, err}, 32'd1);
        chk("err_nodone", {31'b0, done}, 32'd0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 256; k++) ld_data[k] = 2'($urandom_range(0, 3));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'b0, s_ready}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_tblv"}, {31'b0, tbl_valid}, 32'd0);
        chk({tag, "_ovld"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_odat"}, {30'b0, out_data}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state and lookup with no table
        repeat (2) step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();
        check_reset_outputs("post_rst");
        lk_force = 1'b1;
        lk_addr  = 8'hC0;
        lk_en    = 1'b1;
        repeat (4) step();

        // 2: single non-zero entry exercises the address reorder
        for (int k = 0; k < 256; k++) ld_data[k] = 2'b00;
        ld_data[3] = 2'b01;
        lk_force = 1'b0;
        start_load();
        send_beats(256, 255);
        expect_commit();
        lk_force = 1'b1;
        lk_addr  = 8'hC0;
        repeat (3) step();
        lk_addr  = 8'h03;
        repeat (3) step();

        // 3: lookups of C0 across a swap to an all-2'b10 table
        for (int k = 0; k < 256; k++) ld_data[k] = 2'b10;
        lk_addr = 8'hC0;
        start_load();
        send_beats(256, 255);
        expect_commit();
        repeat (3) step();

        // 4: early s_last leaves the active table alone and sets err
        lk_force = 1'b0;
        fill_random();
        start_load();
        send_beats(101, 100);
        expect_error();
        repeat (20) step();
        chk("err_sticky", {31'b0, err}, 32'd1);

        // missing s_last on the final beat is also malformed
        start_load();
        send_beats(256, -1);
        expect_error();
        repeat (10) step();

        // 5: restart part-way, then a full load; only the second pass lands
        fill_random();
        start_load();
        send_beats(50, -1);
        fill_random();
        start_load();
        send_beats(256, 255);
        expect_commit();
        repeat (40) step();

        // 6: reset mid-load
        fill_random();
        start_load();
        send_beats(128, -1);
        lk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        tbl_m = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        rst_n = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", {31'b0, s_ready}, 32'd0);
            chk("stall_busy", {31'b0, busy}, 32'd0);
        end
        s_valid = 1'b0;
        lk_en = 1'b1;
        repeat (10) step();

        // Random full loads with concurrent random lookups
        for (int r = 0; r < 3; r++) begin
            fill_random();
            start_load();
            send_beats(256, 255);
            expect_commit();
            repeat (30) step();
        end

        lk_en = 1'b0;
        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
